gt_core_p: RTL and testbench

Parametrised successor to the 8-bit Gigatron-style CPU core. It fetches 16-bit instruction words (IR:D) from an external ROM and executes one instruction per clock through a two-stage fetch/execute pipeline with one branch delay slot. The data path is generalised to DW bits, with a DW-bit IN port and register-mapped outputs. It sits between program ROM, data RAM and the video/IO pins, and replaces the fixed-width core wrapper.

---
 rtl/gt_pkg.sv | 56 +++++
 rtl/gt_alu.sv | 26 ++
 rtl/gt_core_p.sv | 152 +++++++++++++++
 tb/tb_gt_core_p.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_pkg.sv
// Shared encodings for the gt_core_p CPU: instruction field enums, the NOP word
// and the branch-condition evaluator.
package gt_pkg;

    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_AND = 3'd1,
        OP_OR  = 3'd2,
        OP_XOR = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_ST  = 3'd6,
        OP_BR  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        M_D_AC   = 3'd0,
        M_X_AC   = 3'd1,
        M_YD_AC  = 3'd2,
        M_YX_AC  = 3'd3,
        M_D_X    = 3'd4,
        M_D_Y    = 3'd5,
        M_D_OUT  = 3'd6,
        M_YX_OUT = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        BUS_D   = 2'd0,
        BUS_RAM = 2'd1,
        BUS_AC  = 2'd2,
        BUS_IN  = 2'd3
    } bus_e;

    // "LD AC": reloads AC with itself, so it changes no state
    localparam logic [7:0] NOP_IR = 8'h02;

    // Branch mode field -> taken, given AC==0 and AC sign bit
    function automatic logic br_taken(input logic [2:0] cond,
                                      input logic       zero,
                                      input logic       neg);
        logic t;
        t = 1'b0;
        unique case (cond)
            3'd0:    t = 1'b1;
            3'd1:    t = !neg && !zero;
            3'd2:    t = neg;
            3'd3:    t = !zero;
            3'd4:    t = zero;
            3'd5:    t = !neg;
            3'd6:    t = neg || zero;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/gt_alu.sv
// Combinational ALU for gt_core_p: LD/AND/OR/XOR/ADD/SUB on BUS and AC,
// with ST and branch passing BUS through unchanged.
module gt_alu
    import gt_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] bus_i,
    input  logic [DW-1:0] ac_i,
    output logic [DW-1:0] res_o
);

    always_comb begin
        res_o = bus_i;
        unique case (op_e'(op_i))
            OP_AND:  res_o = ac_i & bus_i;
            OP_OR:   res_o = ac_i | bus_i;
            OP_XOR:  res_o = ac_i ^ bus_i;
            OP_ADD:  res_o = ac_i + bus_i;
            OP_SUB:  res_o = ac_i - bus_i;
            default: res_o = bus_i;
        endcase
    end

endmodule

// File: rtl/gt_core_p.sv
// gt_core_p: DW-wide Gigatron-style CPU, fetch/execute pipeline with one branch
// delay slot. Define CORE_OUTX_EN to add OUTX, loaded from AC when OUT[DW-2] rises.
module gt_core_p
    import gt_pkg::*;
#(
    parameter int              DW       = 8,
    parameter logic [2*DW-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic [2*DW-1:0] ROM_A,
    input  logic [7:0]      ROM_IR,
    input  logic [DW-1:0]   ROM_D,
    output logic [2*DW-1:0] RAM_A,
    input  logic [DW-1:0]   RAM_RD,
    output logic [DW-1:0]   RAM_WD,
    output logic            RAM_WE,
    input  logic [DW-1:0]   IN,
    output logic [DW-1:0]   AC,
    output logic [DW-1:0]   X,
    output logic [DW-1:0]   Y,
`ifdef CORE_OUTX_EN
    output logic [DW-1:0]   OUT,
    output logic [DW-1:0]   OUTX
`else
    output logic [DW-1:0]   OUT
`endif
);

    localparam int AW = 2 * DW;

    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    ir_q, ir_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] out_q, out_d;

    op_e           op;
    mode_e         mode;
    bus_e          bsel;
    logic [DW-1:0] bus;
    logic [DW-1:0] alu_res;
    logic          st_nop;
    logic          taken;

    assign op   = op_e'(ir_q[7:5]);
    assign mode = mode_e'(ir_q[4:2]);
    assign bsel = bus_e'(ir_q[1:0]);

    always_comb begin
        bus = d_q;
        unique case (bsel)
            BUS_RAM: bus = RAM_RD;
            BUS_AC:  bus = ac_q;
            BUS_IN:  bus = IN;
            default: bus = d_q;
        endcase
    end

    gt_alu #(.DW(DW)) u_alu (
        .op_i  (ir_q[7:5]),
        .bus_i (bus),
        .ac_i  (ac_q),
        .res_o (alu_res)
    );

    // Branches reuse the mode field as the condition, so they always address [D]
    always_comb begin
        RAM_A = {{DW{1'b0}}, d_q};
        if (op != OP_BR) begin
            unique case (mode)
                M_X_AC:             RAM_A = {{DW{1'b0}}, x_q};
                M_YD_AC:            RAM_A = {y_q, d_q};
                M_YX_AC, M_YX_OUT:  RAM_A = {y_q, x_q};
                default:            RAM_A = {{DW{1'b0}}, d_q};
            endcase
        end
    end

    // ST sourcing from RAM would be a read-modify-write on one port; it is a no-op instead
    assign st_nop = (op == OP_ST) && (bsel == BUS_RAM);
    assign RAM_WE = RST_N && (op == OP_ST) && !st_nop;
    assign RAM_WD = bus;
    assign taken  = (op == OP_BR) && br_taken(ir_q[4:2], ac_q == '0, ac_q[DW-1]);

    always_comb begin
        pc_d  = pc_q + AW'(1);
        ir_d  = ROM_IR;
        d_d   = ROM_D;
        ac_d  = ac_q;
        x_d   = x_q;
        y_d   = y_q;
        out_d = out_q;
        if (taken) begin
            // JMP takes its page from Y; conditional branches stay in the current page
            if (ir_q[4:2] == 3'd0) pc_d = {y_q, bus};
            else                   pc_d = {pc_q[AW-1:DW], bus};
        end else if (op != OP_BR && !st_nop) begin
            unique case (mode)
                M_D_X:   x_d   = alu_res;
                M_D_Y:   y_d   = alu_res;
                M_D_OUT: out_d = alu_res;
                M_YX_OUT: begin
                    out_d = alu_res;
                    x_d   = x_q + DW'(1);
                end
                default: if (op != OP_ST) ac_d = alu_res;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= RESET_PC;
            ir_q  <= NOP_IR;
            d_q   <= '0;
            ac_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            out_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            d_q   <= d_d;
            ac_q  <= ac_d;
            x_q   <= x_d;
            y_q   <= y_d;
            out_q <= out_d;
        end
    end

    assign ROM_A = pc_q;
    assign AC    = ac_q;
    assign X     = x_q;
    assign Y     = y_q;
    assign OUT   = out_q;

`ifdef CORE_OUTX_EN
    logic [DW-1:0] outx_q;

    // Rising edge of OUT[DW-2] (hsync) captures AC
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                              outx_q <= '0;
        else if (!out_q[DW-2] && out_d[DW-2])    outx_q <= ac_q;
    end

    assign OUTX = outx_q;
`endif

endmodule

// File: tb/tb_gt_core_p.sv
// Directed bench for gt_core_p: table-driven ALU/addressing program at DW=8,
// hand sequences for reset, branches/delay slot, and a DW=16 OUT/OUTX run.
module tb_gt_core_p;
    import gt_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_a;
    logic [7:0]  rom_ir;
    logic [7:0]  rom_d;
    logic [15:0] ram_a;
    logic [7:0]  ram_rd;
    logic [7:0]  ram_wd;
    logic        ram_we;
    logic [7:0]  in_p;
    logic [7:0]  ac, x, y, out_p;
`ifdef CORE_OUTX_EN
    logic [7:0]  outx;
`endif

    logic        rst16_n;
    logic [31:0] rom16_a;
    logic [7:0]  rom16_ir;
    logic [15:0] rom16_d;
    logic [31:0] ram16_a;
    logic [15:0] ram16_rd;
    logic [15:0] ram16_wd;
    logic        ram16_we;
    logic [15:0] in16;
    logic [15:0] ac16, x16, y16, out16;
`ifdef CORE_OUTX_EN
    logic [15:0] outx16;
`endif

    logic [7:0]  rom_ir_m [0:65535];
    logic [7:0]  rom_d_m  [0:65535];
    logic [7:0]  ram_m    [0:65535];
    logic [7:0]  rom16_ir_m [0:15];
    logic [15:0] rom16_d_m  [0:15];

    logic        pre_we;
    logic [15:0] pre_a;
    logic [7:0]  pre_d;

    int n_chk;
    int n_fail;

    gt_core_p #(.DW(8), .RESET_PC(16'h0000)) dut (
        .CLK(clk), .RST_N(rst_n), .ROM_A(rom_a), .ROM_IR(rom_ir), .ROM_D(rom_d),
        .RAM_A(ram_a), .RAM_RD(ram_rd), .RAM_WD(ram_wd), .RAM_WE(ram_we), .IN(in_p),
        .AC(ac), .X(x), .Y(y),
`ifdef CORE_OUTX_EN
        .OUT(out_p), .OUTX(outx)
`else
        .OUT(out_p)
`endif
    );

    gt_core_p #(.DW(16), .RESET_PC(32'h0000_0000)) dut16 (
        .CLK(clk), .RST_N(rst16_n), .ROM_A(rom16_a), .ROM_IR(rom16_ir), .ROM_D(rom16_d),
        .RAM_A(ram16_a), .RAM_RD(ram16_rd), .RAM_WD(ram16_wd), .RAM_WE(ram16_we), .IN(in16),
        .AC(ac16), .X(x16), .Y(y16),
`ifdef CORE_OUTX_EN
        .OUT(out16), .OUTX(outx16)
`else
        .OUT(out16)
`endif
    );

    assign rom_ir   = rom_ir_m[rom_a];
    assign rom_d    = rom_d_m[rom_a];
    assign ram_rd   = ram_m[ram_a];
    assign rom16_ir = (rom16_a < 32'd16) ? rom16_ir_m[rom16_a[3:0]] : NOP_IR;
    assign rom16_d  = (rom16_a < 32'd16) ? rom16_d_m[rom16_a[3:0]] : 16'h0000;
    assign ram16_rd = 16'h0000;

    always @(posedge clk) begin
        if (pre_we)      ram_m[pre_a] <= pre_d;
        else if (ram_we) ram_m[ram_a] <= ram_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 65536; i++) begin
            rom_ir_m[i] = NOP_IR;
            rom_d_m[i]  = 8'h00;
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [7:0] ir, input logic [7:0] d);
        rom_ir_m[a] = ir;
        rom_d_m[a]  = d;
    endtask

    typedef struct {
        logic [7:0]  ir;
        logic [7:0]  d;
        logic        we;
        logic [15:0] ra;
        logic [7:0]  ac, x, y, out;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    logic [15:0] exp_pc [13];
    logic [7:0]  ir16  [7];
    logic [15:0] d16   [7];
    logic [15:0] eac16 [7];
    logic [15:0] eout16[7];
    logic [15:0] eoutx16[7];

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        rst16_n = 1'b0;
        in_p    = 8'h5A;
        in16    = 16'h0000;
        pre_we  = 1'b0;
        pre_a   = '0;
        pre_d   = '0;

        //          ir     d      we    ram_a     ac     x      y      out
        vt[0]  = '{8'h00, 8'h05, 1'b0, 16'h0005, 8'h05, 8'h00, 8'h00, 8'h00}; // LD $05
        vt[1]  = '{8'h80, 8'hFE, 1'b0, 16'h00FE, 8'h03, 8'h00, 8'h00, 8'h00}; // ADD $FE
        vt[2]  = '{8'hA0, 8'h04, 1'b0, 16'h0004, 8'hFF, 8'h00, 8'h00, 8'h00}; // SUB $04
        vt[3]  = '{8'h20, 8'h0F, 1'b0, 16'h000F, 8'h0F, 8'h00, 8'h00, 8'h00}; // AND $0F
        vt[4]  = '{8'h40, 8'h30, 1'b0, 16'h0030, 8'h3F, 8'h00, 8'h00, 8'h00}; // OR $30
        vt[5]  = '{8'h60, 8'hFF, 1'b0, 16'h00FF, 8'hC0, 8'h00, 8'h00, 8'h00}; // XOR $FF
        vt[6]  = '{8'h10, 8'hAA, 1'b0, 16'h00AA, 8'hC0, 8'hAA, 8'h00, 8'h00}; // LD X,$AA
        vt[7]  = '{8'h14, 8'h55, 1'b0, 16'h0055, 8'hC0, 8'hAA, 8'h55, 8'h00}; // LD Y,$55
        vt[8]  = '{8'h1A, 8'h00, 1'b0, 16'h0000, 8'hC0, 8'hAA, 8'h55, 8'hC0}; // LD OUT,AC
        vt[9]  = '{8'h03, 8'h00, 1'b0, 16'h0000, 8'h5A, 8'hAA, 8'h55, 8'hC0}; // LD IN
        vt[10] = '{8'hC2, 8'h40, 1'b1, 16'h0040, 8'h5A, 8'hAA, 8'h55, 8'hC0}; // ST AC,[$40]
        vt[11] = '{8'h80, 8'h01, 1'b0, 16'h0001, 8'h5B, 8'hAA, 8'h55, 8'hC0}; // ADD $01
        vt[12] = '{8'h01, 8'h40, 1'b0, 16'h0040, 8'h5A, 8'hAA, 8'h55, 8'hC0}; // LD [$40]
        vt[13] = '{8'h89, 8'h10, 1'b0, 16'h5510, 8'h6B, 8'hAA, 8'h55, 8'hC0}; // ADD [Y,$10]
        vt[14] = '{8'hDC, 8'h77, 1'b1, 16'h55AA, 8'h6B, 8'hAB, 8'h55, 8'h77}; // ST $77,[Y,X++],OUT
        vt[15] = '{8'h05, 8'h00, 1'b0, 16'h00AB, 8'h3C, 8'hAB, 8'h55, 8'h77}; // LD [X]
        vt[16] = '{8'h0D, 8'h00, 1'b0, 16'h55AB, 8'h99, 8'hAB, 8'h55, 8'h77}; // LD [Y,X]
        vt[17] = '{8'hC1, 8'h40, 1'b0, 16'h0040, 8'h99, 8'hAB, 8'h55, 8'h77}; // ST RAM -> no-op
        vt[18] = '{8'h10, 8'hAA, 1'b0, 16'h00AA, 8'h99, 8'hAA, 8'h55, 8'h77}; // LD X,$AA
        vt[19] = '{8'h0D, 8'h00, 1'b0, 16'h55AA, 8'h77, 8'hAA, 8'h55, 8'h77}; // LD [Y,X]
        vt[20] = '{8'hD7, 8'h42, 1'b1, 16'h0042, 8'h77, 8'hAA, 8'h5A, 8'h77}; // ST IN,[$42],Y
        vt[21] = '{8'h01, 8'h42, 1'b0, 16'h0042, 8'h5A, 8'hAA, 8'h5A, 8'h77}; // LD [$42]

        exp_pc = '{16'h0001, 16'h0002, 16'h0003, 16'h0300, 16'h0301, 16'h0310, 16'h0311,
                   16'h0312, 16'h1234, 16'h1235, 16'h1236, 16'h1237, 16'h1238};

        ir16    = '{8'h00, 8'h18, 8'h18, 8'h00, 8'h18, 8'h18, 8'h18};
        d16     = '{16'hBEEF, 16'h0000, 16'h4000, 16'h1234, 16'hC000, 16'h0000, 16'h4001};
        eac16   = '{16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        eout16  = '{16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'hC000, 16'h0000, 16'h4001};
        eoutx16 = '{16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h1234};
        for (int i = 0; i < 16; i++) begin
            rom16_ir_m[i] = NOP_IR;
            rom16_d_m[i]  = 16'h0000;
        end
        for (int i = 0; i < 7; i++) begin
            rom16_ir_m[i] = ir16[i];
            rom16_d_m[i]  = d16[i];
        end

        // ---- table program at DW=8 ----
        clear_rom();
        for (int k = 0; k < NV; k++) put(16'(k), vt[k].ir, vt[k].d);
        put(16'(NV), 8'hC2, 8'h41);
        preload(16'h5510, 8'h11);
        preload(16'h00AB, 8'h3C);
        preload(16'h55AB, 8'h99);

        @(negedge clk);
        chk("reset rom_a", 32'(rom_a), 32'h0);
        chk("reset ac", 32'(ac), 32'h0);
        chk("reset x", 32'(x), 32'h0);
        chk("reset y", 32'(y), 32'h0);
        chk("reset out", 32'(out_p), 32'h0);
        chk("reset ram_we", 32'(ram_we), 32'h0);
        rst_n = 1'b1;
        chk("first fetch addr", 32'(rom_a), 32'h0);
        @(posedge clk);
        #1;
        for (int k = 0; k < NV; k++) begin
            chk($sformatf("we[%0d]", k), 32'(ram_we), 32'(vt[k].we));
            chk($sformatf("ram_a[%0d]", k), 32'(ram_a), 32'(vt[k].ra));
            if (vt[k].we) chk($sformatf("ram_wd[%0d]", k), 32'(ram_wd), 32'(vt[k].ir == 8'hC2 ? vt[k-1].ac :
                                                                     vt[k].ir == 8'hD7 ? in_p : vt[k].d));
            @(posedge clk);
            #1;
            chk($sformatf("ac[%0d]", k), 32'(ac), 32'(vt[k].ac));
            chk($sformatf("x[%0d]", k), 32'(x), 32'(vt[k].x));
            chk($sformatf("y[%0d]", k), 32'(y), 32'(vt[k].y));
            chk($sformatf("out[%0d]", k), 32'(out_p), 32'(vt[k].out));
        end

        // ---- async reset while a store is in E ----
        chk("st we before reset", 32'(ram_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrun reset rom_a", 32'(rom_a), 32'h0);
        chk("midrun reset ac", 32'(ac), 32'h0);
        chk("midrun reset x", 32'(x), 32'h0);
        chk("midrun reset y", 32'(y), 32'h0);
        chk("midrun reset out", 32'(out_p), 32'h0);
        chk("midrun reset ram_we", 32'(ram_we), 32'h0);

        // ---- branches and delay slots ----
        clear_rom();
        put(16'h0000, 8'h14, 8'h03);  // LD Y,$03
        put(16'h0001, 8'h00, 8'h01);  // LD $01
        put(16'h0002, 8'hE0, 8'h00);  // JMP Y,$00
        put(16'h0003, 8'h10, 8'h07);  // delay slot: LD X,$07
        put(16'h0004, 8'h00, 8'hEE);  // skipped
        put(16'h0300, 8'hEC, 8'h10);  // BNE $10
        put(16'h0301, 8'h00, 8'h22);  // delay slot: LD $22
        put(16'h0302, 8'h00, 8'h99);  // skipped
        put(16'h0310, 8'h14, 8'h12);  // LD Y,$12
        put(16'h0311, 8'hE0, 8'h34);  // JMP Y,$34
        put(16'h0312, 8'h00, 8'h80);  // delay slot: LD $80
        put(16'h0313, 8'h00, 8'h55);  // skipped
        put(16'h1234, 8'hF0, 8'h00);  // BEQ $00 (not taken)
        put(16'h1235, 8'h10, 8'h5E);  // LD X,$5E
        put(16'h1236, 8'h18, 8'h61);  // LD OUT,$61
        @(negedge clk);
        rst_n = 1'b1;
        chk("br first fetch", 32'(rom_a), 32'h0);
        for (int n = 1; n <= 13; n++) begin
            @(posedge clk);
            #1;
            chk($sformatf("br pc edge%0d", n), 32'(rom_a), 32'(exp_pc[n-1]));
            case (n)
                4:  chk("br y after ld", 32'(y), 32'h03);
                5:  chk("jmp delay slot x", 32'(x), 32'h07);
                6:  chk("jmp skipped ac", 32'(ac), 32'h01);
                7:  chk("bne delay slot ac", 32'(ac), 32'h22);
                8:  chk("br y12", 32'(y), 32'h12);
                10: chk("jmp2 delay slot ac", 32'(ac), 32'h80);
                12: chk("beq fallthru x", 32'(x), 32'h5E);
                13: chk("beq fallthru out", 32'(out_p), 32'h61);
                default: ;
            endcase
        end

        // ---- DW=16 OUT / OUTX ----
        @(negedge clk);
        rst16_n = 1'b1;
        chk("dw16 first fetch", rom16_a, 32'h0);
        @(posedge clk);
        #1;
        chk("dw16 ram_a", ram16_a, 32'h0000BEEF);
        chk("dw16 ram_wd", 32'(ram16_wd), 32'h0000BEEF);
        chk("dw16 ram_we", 32'(ram16_we), 32'h0);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("dw16 ac[%0d]", k), 32'(ac16), 32'(eac16[k]));
            chk($sformatf("dw16 out[%0d]", k), 32'(out16), 32'(eout16[k]));
`ifdef CORE_OUTX_EN
            chk($sformatf("dw16 outx[%0d]", k), 32'(outx16), 32'(eoutx16[k]));
`endif
        end
        chk("dw16 x", 32'(x16), 32'h0);
        chk("dw16 y", 32'(y16), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
